// File: rtl/ahb_burst_master_if.sv
// rtl/ahb_burst_master_if.sv - command, write/read stream, status and AHB-Lite bus bundle for ahb_burst_master
interface ahb_burst_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 12
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_BITS-1:0]  cmd_addr_i;
  logic [1:0]            cmd_len_i;

  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  wdata_valid_i;
  logic                  wdata_ready_o;

  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  rdata_valid_o;
  logic                  done_o;
  logic                  err_o;

  logic [ADDR_BITS-1:0]  haddr_o;
  logic [1:0]            htrans_o;
  logic                  hwrite_o;
  logic [2:0]            hsize_o;
  logic [2:0]            hburst_o;
  logic [3:0]            hprot_o;
  logic                  hmasterlock_o;
  logic [3:0]            hstrb_o;
  logic [DATA_WIDTH-1:0] hwdata_o;
  logic                  hready_i;
  logic                  hresp_i;
  logic [DATA_WIDTH-1:0] hrdata_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
    input  wdata_i, wdata_valid_i,
    input  hready_i, hresp_i, hrdata_i,
    output cmd_ready_o, wdata_ready_o, rdata_o, rdata_valid_o, done_o, err_o,
    output haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hprot_o,
    output hmasterlock_o, hstrb_o, hwdata_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
    output wdata_i, wdata_valid_i,
    output hready_i, hresp_i, hrdata_i,
    input  cmd_ready_o, wdata_ready_o, rdata_o, rdata_valid_o, done_o, err_o,
    input  haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hprot_o,
    input  hmasterlock_o, hstrb_o, hwdata_o
  );
endinterface

// File: rtl/ahb_burst_master.sv
// rtl/ahb_burst_master.sv - AHB-Lite INCR burst master with pipelined address/data phases
// htrans is combinational so BUSY/IDLE insertion follows wdata_valid_i without a bubble.
module ahb_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 12
) (
  input logic               hclk_i,
  input logic               hrst_i,
  ahb_burst_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA_LAST, ERR} state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  state_t                state_q, state_n;
  logic [ADDR_BITS-1:0]  haddr_q, haddr_n;
  logic                  hwrite_q, hwrite_n;
  logic [2:0]            hburst_q, hburst_n;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_n;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
  logic [4:0]            beats_q, beats_n;
  logic                  first_q, first_n;
  logic                  dphase_q, dphase_n;
  logic                  stall_q, stall_n;
  logic [1:0]            hold_trans_q, hold_trans_n;
  logic                  rvalid_q, rvalid_n;
  logic                  done_q, done_n;
  logic                  err_q, err_n;

  logic [1:0]            htrans_c;
  logic                  err_now;
  logic                  addr_done;
  logic                  wdata_rdy;

  logic [4:0]            cmd_beats;
  logic [4:0]            beats_m1;
  logic [2:0]            cmd_burst;
  logic [10:0]           last_off;
  logic                  crosses;

  always_comb begin
    cmd_beats = 5'd16;
    cmd_burst = 3'b111;
    case (bus.cmd_len_i)
      2'b00:   begin cmd_beats = 5'd1; cmd_burst = 3'b000; end
      2'b01:   begin cmd_beats = 5'd4; cmd_burst = 3'b011; end
      2'b10:   begin cmd_beats = 5'd8; cmd_burst = 3'b101; end
      default: begin cmd_beats = 5'd16; cmd_burst = 3'b111; end
    endcase
    beats_m1 = cmd_beats - 5'd1;
    // a carry out of the 1 KB page offset means the last beat lands in the next page
    last_off = {1'b0, bus.cmd_addr_i[9:0]} + {4'd0, beats_m1, 2'b00};
    crosses  = last_off[10];
  end

  always_comb begin
    state_n      = state_q;
    haddr_n      = haddr_q;
    hwrite_n     = hwrite_q;
    hburst_n     = hburst_q;
    hwdata_n     = hwdata_q;
    rdata_n      = rdata_q;
    beats_n      = beats_q;
    first_n      = first_q;
    dphase_n     = dphase_q;
    stall_n      = 1'b0;
    hold_trans_n = TR_IDLE;
    rvalid_n     = 1'b0;
    done_n       = 1'b0;
    err_n        = 1'b0;

    htrans_c = TR_IDLE;
    if (state_q == ADDR) begin
      // a waited address phase keeps exactly what it presented last cycle
      if (stall_q)
        htrans_c = hold_trans_q;
      else if (!hwrite_q || bus.wdata_valid_i)
        htrans_c = first_q ? TR_NONSEQ : TR_SEQ;
      else
        htrans_c = first_q ? TR_IDLE : TR_BUSY;
    end
    err_now = dphase_q && bus.hresp_i && (state_q == ADDR || state_q == DATA_LAST);
    if (err_now)
      htrans_c = TR_IDLE;
    addr_done = bus.hready_i && (htrans_c == TR_NONSEQ || htrans_c == TR_SEQ);
    wdata_rdy = addr_done && hwrite_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          if (crosses) begin
            done_n = 1'b1;
            err_n  = 1'b1;
          end else begin
            state_n  = ADDR;
            haddr_n  = bus.cmd_addr_i;
            hwrite_n = bus.cmd_write_i;
            hburst_n = cmd_burst;
            beats_n  = cmd_beats;
            first_n  = 1'b1;
            dphase_n = 1'b0;
          end
        end
      end
      ADDR: begin
        stall_n      = !bus.hready_i;
        hold_trans_n = htrans_c;
        if (err_now) begin
          dphase_n = 1'b0;
          if (bus.hready_i) begin
            done_n  = 1'b1;
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = ERR;
          end
        end else if (bus.hready_i) begin
          if (dphase_q && !hwrite_q) begin
            rdata_n  = bus.hrdata_i;
            rvalid_n = 1'b1;
          end
          dphase_n = addr_done;
          if (addr_done) begin
            haddr_n = haddr_q + ADDR_BITS'(4);
            beats_n = beats_q - 5'd1;
            first_n = 1'b0;
            if (hwrite_q)
              hwdata_n = bus.wdata_i;
            if (beats_q == 5'd1)
              state_n = DATA_LAST;
          end
        end
      end
      DATA_LAST: begin
        if (err_now) begin
          dphase_n = 1'b0;
          if (bus.hready_i) begin
            done_n  = 1'b1;
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = ERR;
          end
        end else if (bus.hready_i) begin
          if (!hwrite_q) begin
            rdata_n  = bus.hrdata_i;
            rvalid_n = 1'b1;
          end
          done_n   = 1'b1;
          dphase_n = 1'b0;
          state_n  = IDLE;
        end
      end
      ERR: begin
        if (bus.hready_i) begin
          done_n  = 1'b1;
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge hclk_i) begin
    if (hrst_i) begin
      state_q      <= IDLE;
      haddr_q      <= '0;
      hwrite_q     <= 1'b0;
      hburst_q     <= 3'b000;
      hwdata_q     <= '0;
      rdata_q      <= '0;
      beats_q      <= 5'd0;
      first_q      <= 1'b0;
      dphase_q     <= 1'b0;
      stall_q      <= 1'b0;
      hold_trans_q <= TR_IDLE;
      rvalid_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_n;
      haddr_q      <= haddr_n;
      hwrite_q     <= hwrite_n;
      hburst_q     <= hburst_n;
      hwdata_q     <= hwdata_n;
      rdata_q      <= rdata_n;
      beats_q      <= beats_n;
      first_q      <= first_n;
      dphase_q     <= dphase_n;
      stall_q      <= stall_n;
      hold_trans_q <= hold_trans_n;
      rvalid_q     <= rvalid_n;
      done_q       <= done_n;
      err_q        <= err_n;
    end
  end

  assign bus.cmd_ready_o   = (state_q == IDLE) && !hrst_i;
  assign bus.wdata_ready_o = wdata_rdy;
  assign bus.rdata_o       = rdata_q;
  assign bus.rdata_valid_o = rvalid_q;
  assign bus.done_o        = done_q;
  assign bus.err_o         = err_q;
  assign bus.haddr_o       = haddr_q;
  assign bus.htrans_o      = htrans_c;
  assign bus.hwrite_o      = hwrite_q;
  assign bus.hsize_o       = 3'b010;
  assign bus.hburst_o      = hburst_q;
  assign bus.hprot_o       = 4'b0011;
  assign bus.hmasterlock_o = 1'b0;
  assign bus.hstrb_o       = 4'hF;
  assign bus.hwdata_o      = hwdata_q;
endmodule

// File: tb/tb_ahb_burst_master.sv
// tb/tb_ahb_burst_master.sv - scoreboard bench for ahb_burst_master with a reactive AHB slave and write-data source
module tb_ahb_burst_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  ahb_burst_master_if #(.DATA_WIDTH(32), .ADDR_BITS(12)) bus ();

  ahb_burst_master #(.DATA_WIDTH(32), .ADDR_BITS(12)) dut (
    .hclk_i (clk),
    .hrst_i (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #500000; $display("FAIL watchdog expired at cycle %0d", cyc); $fatal(1); end

  logic [63:0] exp_ad[$];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_wd[$];
  logic [31:0] wq[$];

  int rv_cnt, done_cnt, err_cnt, busy_cnt, aph_cnt, eidle_cnt;
  int err_beat = 0, gap_after = -1, gap_len = 0, gap_cnt = 0, taken = 0, ph_cnt = 0;
  logic hold_low = 1'b0;

  logic snap_hready, snap_take, snap_aph, snap_hwrite;
  logic [11:0] snap_haddr;
  logic dp_valid = 1'b0, dp_write = 1'b0;
  logic [11:0] dp_addr = '0;
  int dp_idx = 0, err_phase = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [11:0] a);
    return 32'hC0DE_0000 | {20'h0, a};
  endfunction

  // monitor / scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    snap_hready = bus.hready_i;
    snap_take   = bus.wdata_valid_i && bus.wdata_ready_o;
    snap_aph    = (bus.htrans_o == 2'b10 || bus.htrans_o == 2'b11) && bus.hready_i;
    snap_haddr  = bus.haddr_o;
    snap_hwrite = bus.hwrite_o;
    if (!rst) begin
      if (bus.rdata_valid_o) begin
        rv_cnt++;
        if (exp_rd.size() == 0) check("rdata_extra", 1, 0);
        else check("rdata", bus.rdata_o, exp_rd.pop_front());
      end
      if (snap_aph) begin
        aph_cnt++;
        if (exp_ad.size() == 0) check("addr_extra", {bus.htrans_o, bus.hwrite_o, bus.haddr_o}, 0);
        else check("addr_phase", {bus.htrans_o, bus.hwrite_o, bus.haddr_o}, exp_ad.pop_front());
      end
      if (bus.htrans_o == 2'b01) begin
        busy_cnt++;
        if (exp_ad.size() != 0) check("busy_haddr", bus.haddr_o, exp_ad[0][11:0]);
      end
      if (dp_valid && dp_write && bus.hready_i && !bus.hresp_i) begin
        if (exp_wd.size() == 0) check("hwdata_extra", 1, 0);
        else check("hwdata", bus.hwdata_o, exp_wd.pop_front());
      end
      if (dp_valid && bus.hresp_i && !bus.hready_i) begin
        eidle_cnt++;
        check("err_htrans_idle", bus.htrans_o, 2'b00);
      end
      if (bus.done_o) done_cnt++;
      if (bus.err_o) err_cnt++;
    end
  end

  // slave and write-data source
  initial begin
    bus.hready_i = 1'b1; bus.hresp_i = 1'b0; bus.hrdata_i = '0;
    bus.wdata_valid_i = 1'b0; bus.wdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        dp_valid = 1'b0; err_phase = 0; wq.delete(); gap_cnt = 0;
      end else begin
        if (snap_take && wq.size() > 0) begin
          void'(wq.pop_front());
          taken++;
          if (taken == gap_after) gap_cnt = gap_len;
        end
        if (snap_hready) begin
          dp_valid = snap_aph; dp_addr = snap_haddr; dp_write = snap_hwrite; err_phase = 0;
          if (snap_aph) begin ph_cnt++; dp_idx = ph_cnt; end
        end
      end
      if (dp_valid && dp_idx == err_beat && err_phase < 2) begin
        err_phase++;
        bus.hresp_i  = 1'b1;
        bus.hready_i = (err_phase == 2);
      end else begin
        bus.hresp_i  = 1'b0;
        bus.hready_i = !hold_low;
      end
      bus.hrdata_i      = (dp_valid && !dp_write) ? rd_word(dp_addr) : 32'h0;
      bus.wdata_valid_i = (wq.size() > 0) && (gap_cnt == 0);
      bus.wdata_i       = (wq.size() > 0) ? wq[0] : 32'h0;
      if (gap_cnt > 0) gap_cnt--;
    end
  end

  task automatic clear_counts();
    rv_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0; aph_cnt = 0; eidle_cnt = 0; ph_cnt = 0;
  endtask

  task automatic send_cmd(input logic w, input logic [11:0] a, input logic [1:0] len, output int t);
    int n;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b1; bus.cmd_write_i = w; bus.cmd_addr_i = a; bus.cmd_len_i = len;
    @(negedge clk);
    n = 0;
    while (!bus.cmd_ready_o && n < 50) begin @(negedge clk); n++; end
    if (!bus.cmd_ready_o) check("cmd_ready_timeout", 0, 1);
    t = cyc;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.done_o) begin dc = cyc; break; end
    end
    if (dc < 0) check("done_timeout", 0, 1);
  endtask

  task automatic push_burst(input logic w, input logic [11:0] a, input int beats, input int ad_n, input int rd_n);
    for (int k = 0; k < beats; k++) begin
      if (k < ad_n) exp_ad.push_back({(k == 0) ? 2'b10 : 2'b11, w, a + 12'(4 * k)});
      if (!w && k < rd_n) exp_rd.push_back(rd_word(a + 12'(4 * k)));
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_htrans"}, bus.htrans_o, 0);
    check({pfx, "_haddr"}, bus.haddr_o, 0);
    check({pfx, "_hwrite"}, bus.hwrite_o, 0);
    check({pfx, "_hburst"}, bus.hburst_o, 0);
    check({pfx, "_hwdata"}, bus.hwdata_o, 0);
    check({pfx, "_rdata"}, bus.rdata_o, 0);
    check({pfx, "_rvalid"}, bus.rdata_valid_o, 0);
    check({pfx, "_done"}, bus.done_o, 0);
    check({pfx, "_err"}, bus.err_o, 0);
    check({pfx, "_cmd_ready"}, bus.cmd_ready_o, 0);
    check({pfx, "_wdata_ready"}, bus.wdata_ready_o, 0);
  endtask

  initial begin
    int t, dc;
    bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_len_i = 2'b00;
    clear_counts();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    check("hsize", bus.hsize_o, 3'b010);
    check("hprot", bus.hprot_o, 4'b0011);
    check("hmasterlock", bus.hmasterlock_o, 0);
    check("hstrb", bus.hstrb_o, 4'hF);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.cmd_ready_o, 1);

    // single write
    clear_counts();
    wq.push_back(32'hA5A5_0001); exp_wd.push_back(32'hA5A5_0001);
    push_burst(1'b1, 12'h010, 1, 1, 0);
    send_cmd(1'b1, 12'h010, 2'b00, t);
    @(negedge clk);
    check("w1_htrans", bus.htrans_o, 2'b10);
    check("w1_haddr", bus.haddr_o, 12'h010);
    check("w1_hburst", bus.hburst_o, 3'b000);
    @(negedge clk);
    check("w1_hwdata", bus.hwdata_o, 32'hA5A5_0001);
    wait_done(dc);
    check("w1_done_cyc", dc, t + 3);
    check("w1_err", bus.err_o, 0);
    repeat (3) @(negedge clk);
    check("w1_queues", exp_ad.size() + exp_wd.size(), 0);

    // INCR4 read, zero-wait
    clear_counts();
    push_burst(1'b0, 12'h100, 4, 4, 4);
    send_cmd(1'b0, 12'h100, 2'b01, t);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("r4_htrans", bus.htrans_o, (k == 0) ? 2'b10 : 2'b11);
      check("r4_haddr", bus.haddr_o, 12'h100 + 12'(4 * k));
    end
    check("r4_hburst", bus.hburst_o, 3'b011);
    wait_done(dc);
    check("r4_done_cyc", dc, t + 6);
    check("r4_last_rvalid", bus.rdata_valid_o, 1);
    repeat (3) @(negedge clk);
    check("r4_rv_cnt", rv_cnt, 4);
    check("r4_done_cnt", done_cnt, 1);
    check("r4_queues", exp_ad.size() + exp_rd.size(), 0);

    // INCR8 write with a two-cycle data gap after beat 3
    clear_counts();
    taken = 0; gap_after = 3; gap_len = 2;
    for (int k = 0; k < 8; k++) begin
      wq.push_back(32'h1000_0000 + k); exp_wd.push_back(32'h1000_0000 + k);
    end
    push_burst(1'b1, 12'h200, 8, 8, 0);
    send_cmd(1'b1, 12'h200, 2'b10, t);
    check("w8_hburst", bus.hburst_o, 3'b101);
    wait_done(dc);
    repeat (3) @(negedge clk);
    check("w8_busy_cnt", busy_cnt, 2);
    check("w8_aph_cnt", aph_cnt, 8);
    check("w8_done_cnt", done_cnt, 1);
    check("w8_err_cnt", err_cnt, 0);
    check("w8_queues", exp_ad.size() + exp_wd.size(), 0);
    gap_after = -1;

    // INCR4 read with slave ERROR on beat 2
    clear_counts();
    err_beat = 2;
    push_burst(1'b0, 12'h180, 4, 2, 1);
    send_cmd(1'b0, 12'h180, 2'b01, t);
    wait_done(dc);
    check("e4_err_with_done", bus.err_o, 1);
    repeat (3) @(negedge clk);
    check("e4_rv_cnt", rv_cnt, 1);
    check("e4_err_cnt", err_cnt, 1);
    check("e4_done_cnt", done_cnt, 1);
    check("e4_idle_seen", eidle_cnt, 1);
    check("e4_queues", exp_ad.size() + exp_rd.size(), 0);
    err_beat = 0;

    // INCR16 across a 1 KB boundary
    clear_counts();
    send_cmd(1'b0, 12'h3F0, 2'b11, t);
    @(negedge clk);
    check("x16_done", bus.done_o, 1);
    check("x16_err", bus.err_o, 1);
    check("x16_htrans", bus.htrans_o, 0);
    repeat (4) @(negedge clk);
    check("x16_aph_cnt", aph_cnt, 0);
    check("x16_done_cnt", done_cnt, 1);

    // reset mid-INCR8 with hready held low
    clear_counts();
    push_burst(1'b0, 12'h240, 8, 8, 8);
    send_cmd(1'b0, 12'h240, 2'b10, t);
    hold_low = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_burst", bus.cmd_ready_o, 0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(posedge clk); #1; rst = 1'b0; hold_low = 1'b0;
    exp_ad.delete(); exp_rd.delete();
    @(negedge clk);
    check("mid_rst_ready", bus.cmd_ready_o, 1);
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_no_err", err_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb_burst_master.md
AHB_BURST_MASTER -- requirements
Module: ahb_burst_master

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the data bus width.
REQ-002 The block SHALL have parameter ADDR_BITS, default 12, the byte-address width; this equals the SRAM word-address bits plus 2.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port hclk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port hrst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have command ports:
  - cmd_valid_i, input, 1.
  - cmd_ready_o, output, 1.
  - cmd_write_i, input, 1: 1 = write.
  - cmd_addr_i, input, ADDR_BITS: byte address, word aligned.
  - cmd_len_i, input, 2: 00 SINGLE, 01 INCR4, 10 INCR8, 11 INCR16.
REQ-006 The block SHALL have write-data ports wdata_i (input, DATA_WIDTH), wdata_valid_i (input, 1) and wdata_ready_o (output, 1).
REQ-007 The block SHALL have read-data ports rdata_o (output, DATA_WIDTH) and rdata_valid_o (output, 1); this path has no backpressure.
REQ-008 The block SHALL have status ports done_o (output, 1) and err_o (output, 1); both are single-cycle pulses.
REQ-009 The block SHALL have AHB-Lite outputs:
  - haddr_o, ADDR_BITS.
  - htrans_o, 2.
  - hwrite_o, 1.
  - hsize_o, 3: constant 3'b010.
  - hburst_o, 3.
  - hprot_o, 4: constant 4'b0011.
  - hmasterlock_o, 1: constant 0.
  - hstrb_o, 4: constant 4'hF.
  - hwdata_o, DATA_WIDTH.
REQ-010 The block SHALL have AHB-Lite inputs hready_i (1), hresp_i (1) and hrdata_i (DATA_WIDTH).

Function
REQ-011 The FSM SHALL have states IDLE, ADDR, DATA_LAST and ERR.
REQ-012 cmd_ready_o SHALL be 1 only in IDLE, when not in reset.
REQ-013 When a command is accepted (cmd_valid_i & cmd_ready_o) at cycle T, the first NONSEQ SHALL appear on htrans_o at T+1.
REQ-014 hburst_o SHALL map cmd_len_i as follows: 00 -> 000, 01 -> 011, 10 -> 101, 11 -> 111.
REQ-015 Beat count SHALL be 1, 4, 8 or 16 according to cmd_len_i.
REQ-016 A command whose last beat crosses a 1 KB boundary SHALL NOT be accepted onto the bus:
  - err_o and done_o pulse at T+1.
  - htrans_o stays IDLE.
  - The FSM returns to IDLE.
REQ-017 Address and control SHALL be pipelined: the address phase of beat n+1 overlaps the data phase of beat n.
REQ-018 haddr_o SHALL advance by 4 per accepted beat; the first beat is NONSEQ and later beats are SEQ.
REQ-019 Address, control and htrans_o SHALL be held stable while hready_i = 0.
REQ-020 Write beats SHALL follow these rules:
  - A beat's address phase is issued only when wdata_valid_i = 1.
  - wdata_ready_o = 1 in the same cycle that the beat's address phase completes (hready_i = 1).
  - The captured word is driven on hwdata_o throughout the following data phase.
REQ-021 If wdata_valid_i = 0 mid-burst, the block SHALL drive htrans_o = BUSY while holding haddr_o.
REQ-022 If wdata_valid_i = 0 before the first beat, htrans_o SHALL remain IDLE in ADDR until data arrives.
REQ-023 Read beats SHALL be returned as follows:
  - rdata_o is registered from hrdata_i.
  - rdata_valid_o = 1 one cycle after each read data phase completes with hready_i = 1 and hresp_i = 0.
REQ-024 After the last address phase, the FSM SHALL enter DATA_LAST and drive htrans_o = IDLE.
REQ-025 When the last data phase completes, done_o SHALL pulse one cycle later and the FSM SHALL return to IDLE; the final rdata_valid_o pulse and done_o occur in the same cycle.
REQ-026 On hresp_i = 1 with hready_i = 0 (first error cycle), the block SHALL enter ERR and drive htrans_o = IDLE; remaining beats are cancelled.
REQ-027 ERR handling SHALL complete as follows:
  - On the second error cycle (hready_i = 1), err_o and done_o pulse the next cycle and the FSM returns to IDLE.
  - No rdata_valid_o is issued for the errored beat.
REQ-028 haddr_o arithmetic SHALL be modulo 2^ADDR_BITS; it never wraps within a legal burst because of REQ-016.
REQ-029 A command presented while not in IDLE SHALL be ignored; cmd_ready_o = 0.

Reset
REQ-030 While hrst_i = 1 at a rising edge of hclk_i, the block SHALL set:
  - FSM to IDLE.
  - htrans_o = 00, haddr_o = 0, hwrite_o = 0, hburst_o = 000, hwdata_o = 0.
  - rdata_o = 0, rdata_valid_o = 0.
  - done_o = 0, err_o = 0.
  - cmd_ready_o = 0, wdata_ready_o = 0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst with no done_o or err_o pulse; cmd_ready_o = 1 on the first cycle after hrst_i deasserts.

Verification
REQ-032 The bench SHALL cover a single write: addr 0x010, data 0xA5A5_0001, hready_i = 1 -> NONSEQ at T+1 with haddr 0x010, hwdata 0xA5A5_0001 at T+2, done_o at T+3.
REQ-033 The bench SHALL cover an INCR4 read at 0x100 with a zero-wait slave -> haddr 0x100/104/108/10C on consecutive cycles (NONSEQ, SEQ, SEQ, SEQ), 4 rdata_valid_o pulses, done_o with the 4th pulse.
REQ-034 The bench SHALL cover an INCR8 write with wdata_valid_i low for 2 cycles after beat 3 -> 2 BUSY cycles at haddr of beat 4, then SEQ resumes, 8 data beats, single done_o.
REQ-035 The bench SHALL cover a slave ERROR on beat 2 of INCR4 read -> htrans_o IDLE in the first error cycle, err_o and done_o pulse, only 1 rdata_valid_o pulse.
REQ-036 The bench SHALL cover an INCR16 at 0x3F0 (crosses 1 KB) -> no bus activity, err_o and done_o at T+1.
REQ-037 The bench SHALL cover hrst_i asserted mid-INCR8 with hready_i held low -> all outputs at reset values next cycle, cmd_ready_o = 1 after release.
